// File: rtl/alu_seq_mdu.sv
// alu_seq_mdu: EX-stage integer unit for the RV32I op set plus RV32M.
// Base ops complete in one cycle. Multiply uses an iterative shift-add loop
// and divide uses a restoring loop, each XLEN cycles long. Results are held
// in a DONE state until the consumer takes them.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready
// (and flush is low). A result transfers on a rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low,
// alu_result and out_valid do not change.
module alu_seq_mdu #(
  parameter int XLEN = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_type,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic [1:0]      dbg_state
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_OR     = 5'd7;
  localparam logic [4:0] OP_AND    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic [XLEN-1:0]    MIN_S   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]    ALL_ONE = {XLEN{1'b1}};
  localparam logic [SHAMT_W-1:0] CNT_MAX = SHAMT_W'(XLEN - 1);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Registered state. hi/lo hold the running product (hi:lo) during MUL and
  // the partial remainder (hi) / shifting dividend-quotient (lo) during DIV.
  // opb holds the multiplicand or divisor magnitude.
  state_e            state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [4:0]        kind_q, kind_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;

  // Start values computed from the incoming request.
  state_e            st_state;
  logic [XLEN-1:0]   st_res, st_lo, st_opb;
  logic              st_neg, st_rneg;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]   base_res;
  logic [XLEN-1:0]   op1_abs, op2_abs;
  logic              op1_neg, op2_neg;
  logic              accept;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_prod, mul_fix;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem, div_quo, q_fix, r_fix;

  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid  = (state_q == S_DONE);
  assign alu_result = res_q;
  assign dbg_state  = state_q;
  assign accept     = in_valid && in_ready && !flush;

  assign shamt   = op2[SHAMT_W-1:0];
  assign op1_neg = op1[XLEN-1];
  assign op2_neg = op2[XLEN-1];
  assign op1_abs = op1_neg ? -op1 : op1;
  assign op2_abs = op2_neg ? -op2 : op2;

  // One shift-add step: add multiplicand when the multiplier LSB is set,
  // then shift the whole (carry:hi:lo) product right by one.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign mul_prod = {mul_sum, lo_q[XLEN-1:1]};
  assign mul_fix  = neg_q ? -mul_prod : mul_prod;

  // One restoring-divide step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only if it did not go negative.
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = !div_diff[XLEN];
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_quo   = {lo_q[XLEN-2:0], div_ge};
  assign q_fix     = neg_q ? -div_quo : div_quo;
  assign r_fix     = rneg_q ? -div_rem : div_rem;

  // Single-cycle RV32I result for the current request.
  always_comb begin
    base_res = '0;
    case (alu_type)
      OP_ADD:  base_res = op1 + op2;
      OP_SUB:  base_res = op1 - op2;
      OP_SLL:  base_res = op1 << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      OP_XOR:  base_res = op1 ^ op2;
      OP_SRL:  base_res = op1 >> shamt;
      OP_OR:   base_res = op1 | op2;
      OP_AND:  base_res = op1 & op2;
      OP_SRA:  base_res = $unsigned($signed(op1) >>> shamt);
      default: base_res = '0;
    endcase
  end

  // Decide how an accepted request starts: directly to DONE, or into an
  // iterative loop with magnitudes and sign-fix flags latched.
  always_comb begin
    st_state = S_DONE;
    st_res   = base_res;
    st_lo    = '0;
    st_opb   = '0;
    st_neg   = 1'b0;
    st_rneg  = 1'b0;
    case (alu_type)
      OP_MUL, OP_MULHU: begin
        // Low half is sign-independent, so MUL shares the unsigned path.
        st_state = S_MUL;
        st_lo    = op2;
        st_opb   = op1;
      end
      OP_MULH: begin
        st_state = S_MUL;
        st_lo    = op2_abs;
        st_opb   = op1_abs;
        st_neg   = op1_neg ^ op2_neg;
      end
      OP_MULHSU: begin
        st_state = S_MUL;
        st_lo    = op2;
        st_opb   = op1_abs;
        st_neg   = op1_neg;
      end
      OP_DIV, OP_REM: begin
        if (op2 == '0) begin
          st_res = (alu_type == OP_DIV) ? ALL_ONE : op1;
        end else if ((op1 == MIN_S) && (op2 == ALL_ONE)) begin
          st_res = (alu_type == OP_DIV) ? op1 : '0;
        end else begin
          st_state = S_DIV;
          st_lo    = op1_abs;
          st_opb   = op2_abs;
          st_neg   = op1_neg ^ op2_neg;
          st_rneg  = op1_neg;
        end
      end
      OP_DIVU, OP_REMU: begin
        if (op2 == '0) begin
          st_res = (alu_type == OP_DIVU) ? ALL_ONE : op1;
        end else begin
          st_state = S_DIV;
          st_lo    = op1;
          st_opb   = op2;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic: iterate, complete, accept, and let flush override all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    kind_d  = kind_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;

    case (state_q)
      S_MUL: begin
        hi_d = mul_prod[2*XLEN-1:XLEN];
        lo_d = mul_prod[XLEN-1:0];
        if (cnt_q == '0) begin
          state_d = S_DONE;
          res_d   = (kind_q == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DIV: begin
        hi_d = div_rem;
        lo_d = div_quo;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          res_d   = ((kind_q == OP_DIV) || (kind_q == OP_DIVU)) ? q_fix : r_fix;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      state_d = st_state;
      cnt_d   = CNT_MAX;
      hi_d    = '0;
      lo_d    = st_lo;
      opb_d   = st_opb;
      kind_d  = alu_type;
      neg_d   = st_neg;
      rneg_d  = st_rneg;
      if (st_state == S_DONE) res_d = st_res;
    end

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // All state registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      kind_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      kind_q  <= kind_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_mdu.sv
// tb_alu_seq_mdu: directed and randomized checks of alu_seq_mdu (XLEN=32)
// against a plain-arithmetic reference model.
module tb_alu_seq_mdu;

  localparam int N_RAND = 2000;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_type;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_fail;
  logic [31:0] exp_q[$];

  alu_seq_mdu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_type   (alu_type),
    .op1        (op1),
    .op2        (op2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: RISC-V semantics from native wide arithmetic.
  function automatic logic [31:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sh = int'(b % 32);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << sh;
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (ua < ub) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> sh;
      5'd7:  return a | b;
      5'd8:  return a & b;
      5'd9:  return 32'(sa >>> sh);
      5'd10: begin p = 64'(sa * sb); return p[31:0]; end
      5'd11: begin p = 64'(sa * sb); return p[63:32]; end
      5'd12: begin p = 64'(sa * ub); return p[63:32]; end
      5'd13: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      5'd14: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      5'd15: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      5'd17: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] rand_op();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(18, 31));
    return 5'($urandom_range(0, 17));
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: issue one op with out_ready high, measure latency, check result.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    int busy_ready;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_type  = op;
    op1       = a;
    op2       = b;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    alu_type = 5'($urandom);
    op1      = $urandom;
    op2      = $urandom;
    n = 1;
    busy_ready = 0;
    #1;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_ready++;
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_res"}, alu_result, exp);
    if (lat > 1) check({tag, "_busy_ready"}, 32'(busy_ready), 32'd0);
  endtask

  initial begin
    int seen;
    int done_n;
    int issued_n;
    int cycles;
    bit acc_last;

    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    alu_type = 5'd0;
    op1 = 32'd0;
    op2 = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_result", alu_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Base ops
    run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
    run_op("sra_33", 5'd9, 32'h8000_0000, 32'h21, 32'hC000_0000, 1);
    run_op("sll_32", 5'd2, 32'h1234_5678, 32'd32, 32'h1234_5678, 1);
    run_op("sub", 5'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run_op("slt", 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu", 5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("srl", 5'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    run_op("and", 5'd8, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1);
    run_op("op20", 5'd20, 32'h1234_5678, 32'h1, 32'd0, 1);

    // Multiply
    run_op("mulh", 5'd11, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);
    run_op("mul", 5'd10, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 33);
    run_op("mulhu", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

    // Divide, including early-outs
    run_op("div", 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem", 5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu", 5'd15, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 5'd17, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_z", 5'd15, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_z", 5'd17, 32'd7, 32'd0, 32'd7, 1);
    run_op("div_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Backpressure then back-to-back issue
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    alu_type = 5'd0;
    op1 = 32'd5;
    op2 = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", alu_result, 32'd11);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    alu_type = 5'd5;
    op1 = 32'h0000_F0F0;
    op2 = 32'h0000_FFFF;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_result", alu_result, 32'h0000_0F0F);

    // Flush in the middle of a DIVU
    @(negedge clk);
    in_valid = 1'b1;
    alu_type = 5'd15;
    op1 = 32'd1000;
    op2 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    alu_type = 5'd0;
    op1 = 32'd1;
    op2 = 32'd2;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_out", 32'(seen), 32'd0);
    run_op("post_flush_add", 5'd0, 32'd40, 32'd2, 32'd42, 1);

    // Asynchronous reset in the middle of a MUL
    @(negedge clk);
    in_valid = 1'b1;
    alu_type = 5'd10;
    op1 = 32'd12345;
    op2 = 32'd678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_result", alu_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("arst_no_out", 32'(seen), 32'd0);
    run_op("post_rst_mul", 5'd10, 32'd12345, 32'd678, 32'd8369910, 33);

    // Randomized traffic with random out_ready, scoreboard via exp_q
    exp_q.delete();
    done_n = 0;
    issued_n = 0;
    cycles = 0;
    acc_last = 1'b0;
    in_valid = 1'b0;
    while (done_n < N_RAND && cycles < 80000) begin
      @(negedge clk);
      cycles++;
      if (acc_last) begin
        in_valid = 1'b0;
        acc_last = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && issued_n < N_RAND && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        alu_type = rand_op();
        op1 = rand_opnd();
        op2 = rand_opnd();
      end
      #1;
      if (out_valid && out_ready) begin
        check("rand_expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rand_result", alu_result, exp_q.pop_front());
        done_n++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_alu(alu_type, op1, op2));
        issued_n++;
        acc_last = 1'b1;
      end
    end
    check("rand_done", 32'(done_n), 32'(N_RAND));

    @(negedge clk);
    in_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
